// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// No logic: state encoding and port identifiers only.
// Imported by mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // Map a port id to the BUSY state that serves it.
    function automatic arb_state_t busy_state(input logic port);
        return (port == PORT_DM) ? BUSY_DM : BUSY_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory; data wins ties.
// Latency: mem_req one cycle after a request from IDLE; ack one cycle after mem_ready.
// Backpressure: requesters stall (req & ~ack) until ack; MEM_ARB_TIMEOUT_EN adds a BUSY timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    arb_state_t    state_q, state_d;
    logic          busy;
    logic          done;
    logic          tmo;
    logic          load_if;
    logic          load_dm;

    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          if_ack_q;
    logic          dm_ack_q;

    assign busy = (state_q != IDLE);
    // mem_ready is only meaningful while a transaction is outstanding.
    assign done = busy & mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_MAX + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;

    // The TMO_MAX-th consecutive not-ready BUSY cycle is the abort cycle.
    assign tmo = busy & ~mem_ready & (tmo_cnt_q == TW'(TMO_MAX - 1));

    // Count not-ready BUSY cycles; restart whenever a new grant is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (load_if | load_dm) begin
            tmo_cnt_q <= '0;
        end else if (busy & ~mem_ready) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // One-cycle abort pulse, aligned with the ack it forces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= tmo;
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    // Grant selection: data first from IDLE, hand-off to the other port on completion.
    always_comb begin
        state_d = state_q;
        load_if = 1'b0;
        load_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    state_d = busy_state(PORT_DM);
                    load_dm = 1'b1;
                end else if (if_req) begin
                    state_d = busy_state(PORT_IF);
                    load_if = 1'b1;
                end
            end
            BUSY_IF: begin
                if (done) begin
                    if (dm_req) begin
                        state_d = busy_state(PORT_DM);
                        load_dm = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            BUSY_DM: begin
                if (done) begin
                    if (if_req) begin
                        state_d = busy_state(PORT_IF);
                        load_if = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request so mem_* stay stable for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (load_dm) begin
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
        end else if (load_if) begin
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end
    end

    // Return path: read data on completion, ack one cycle later (also on abort).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
        end else begin
            if_ack_q <= (state_q == BUSY_IF) & (done | tmo);
            dm_ack_q <= (state_q == BUSY_DM) & (done | tmo);
            if ((state_q == BUSY_IF) && done) begin
                if_rdata_q <= mem_rdata;
            end
            if ((state_q == BUSY_DM) && done && !we_q) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ack    = dm_ack_q;

    assign if_stall  = if_req & ~if_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic.
// Outputs are compared every cycle on the falling edge against a transaction-level model.
// Requesters hold until ack; some randomly drop a request while it is being served.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TMO_MAX(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and what it returns.
    int          m_port;
    int          m_wait;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic        m_we, m_if_ack, m_dm_ack, m_err;

    task automatic model_reset();
        m_port = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0;
        m_if_rdata = '0; m_dm_rdata = '0;
        m_if_ack = 1'b0; m_dm_ack = 1'b0; m_err = 1'b0;
    endtask

    task automatic grant(input int p);
        m_port = p;
        m_wait = 0;
        if (p == 2) begin
            m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        end else begin
            m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
        end
    endtask

    // One clock of arbitration using the inputs currently applied.
    task automatic model_advance();
        int   served;
        logic n_if_ack, n_dm_ack, n_err;
        served   = m_port;
        n_if_ack = 1'b0; n_dm_ack = 1'b0; n_err = 1'b0;
        if (served == 0) begin
            if (dm_req) grant(2);
            else if (if_req) grant(1);
        end else if (mem_ready) begin
            if (served == 1) begin
                m_if_rdata = mem_rdata; n_if_ack = 1'b1;
            end else begin
                if (!m_we) m_dm_rdata = mem_rdata;
                n_dm_ack = 1'b1;
            end
            m_port = 0;
            if (served == 1 && dm_req) grant(2);
            else if (served == 2 && if_req) grant(1);
        end else begin
            m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
            if (m_wait == TMO) begin
                m_port = 0;
                n_err  = 1'b1;
                if (served == 1) n_if_ack = 1'b1;
                else n_dm_ack = 1'b1;
            end
`endif
        end
        m_if_ack = n_if_ack; m_dm_ack = n_dm_ack; m_err = n_err;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_port != 0});
        if (m_port != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", {31'd0, if_ack}, {31'd0, m_if_ack});
        chk("dm_ack", {31'd0, dm_ack}, {31'd0, m_dm_ack});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("dm_rdata", dm_rdata, m_dm_rdata);
        chk("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~m_if_ack});
        chk("dm_stall", {31'd0, dm_stall}, {31'd0, dm_req & ~m_dm_ack});
    endtask

    // Apply inputs just after a rising edge, then compare on the falling edge.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic rdy, input logic [31:0] rd);
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        mem_ready = rdy; mem_rdata = rd;
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
            tick();
        end
    endtask

    // Assert reset mid-cycle and check every output clears immediately.
    task automatic reset_cycle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int          stall_cnt;
        int          busy_cnt;
        int          err_cnt;
        logic        if_pend, dm_pend, ir, dr, dm_w;
        logic [31:0] if_a, dm_a, dm_d;

        model_reset();
        @(posedge clk);
        #1;
        reset_cycle();

        // Single fetch, memory ready on the second BUSY cycle.
        stall_cnt = 0;
        drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        stall_cnt += int'(if_stall); tick();
        drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        stall_cnt += int'(if_stall);
        chk("fetch_mem_addr", mem_addr, 32'h10);
        chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b1, 32'h1234_5678);
        stall_cnt += int'(if_stall); tick();
        drive(1'b0, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        stall_cnt += int'(if_stall);
        chk("fetch_ack", {31'd0, if_ack}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h1234_5678);
        tick();
        chk("fetch_stall_cycles", stall_cnt, 32'd3);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("fetch_ack_width", {31'd0, if_ack}, 32'd0);
        tick();

        // Simultaneous fetch and store: store first, fetch with no gap.
        drive(1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, '0);
        tick();
        drive(1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 32'h5555_AAAA);
        chk("tie_dm_first_we", {31'd0, mem_we}, 32'd1);
        chk("tie_dm_first_addr", mem_addr, 32'h40);
        tick();
        drive(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0BAD_F00D);
        chk("tie_no_gap", {31'd0, mem_req}, 32'd1);
        chk("tie_if_addr", mem_addr, 32'h20);
        chk("tie_dm_ack_first", {31'd0, dm_ack}, 32'd1);
        chk("tie_if_not_yet", {31'd0, if_ack}, 32'd0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("tie_if_ack", {31'd0, if_ack}, 32'd1);
        chk("tie_store_keeps_rdata", dm_rdata, 32'd0);
        tick();
        idle(2);

        // Held data load with continuous fetch: grants alternate dm, if, dm.
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h8, '0, 1'b1, 32'hA0);
        tick();
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h8, '0, 1'b1, 32'hA1);
        chk("alt_g1_dm", mem_addr, 32'h8);
        tick();
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h8, '0, 1'b1, 32'hA2);
        chk("alt_g2_if", mem_addr, 32'h30);
        chk("alt_dm_ack1", {31'd0, dm_ack}, 32'd1);
        tick();
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h8, '0, 1'b1, 32'hA3);
        chk("alt_g3_dm", mem_addr, 32'h8);
        chk("alt_if_ack", {31'd0, if_ack}, 32'd1);
        chk("alt_dm_ack_width", {31'd0, dm_ack}, 32'd0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hA4);
        chk("alt_dm_ack2", {31'd0, dm_ack}, 32'd1);
        chk("alt_if_ack_width", {31'd0, if_ack}, 32'd0);
        tick();
        idle(3);

        // Reset while a data load is outstanding.
        drive(1'b0, '0, 1'b1, 1'b0, 32'h44, '0, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h44, '0, 1'b0, '0);
        chk("pre_rst_busy", {31'd0, mem_req}, 32'd1);
        tick();
        dm_req = 1'b0;
        reset_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFF_FFFF);
            chk("post_rst_no_ack", {31'd0, dm_ack}, 32'd0);
            tick();
        end

        // Memory never ready.
        busy_cnt = 0;
        err_cnt  = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        for (int i = 0; i < TMO; i++) begin
            drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, 1'b0, '0);
            busy_cnt += int'(mem_req);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("tmo_busy_cycles", busy_cnt, TMO);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_if_ack", {31'd0, if_ack}, 32'd1);
        chk("tmo_idle", {31'd0, mem_req}, 32'd0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("tmo_err_width", {31'd0, err}, 32'd0);
        tick();
`else
        drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, 1'b0, '0);
            busy_cnt += int'(mem_req);
            err_cnt  += int'(err);
            tick();
        end
        chk("wait_busy_cycles", busy_cnt, 32'd100);
        chk("wait_no_err", err_cnt, 32'd0);
        drive(1'b0, 32'h50, 1'b0, 1'b0, '0, '0, 1'b1, 32'h7777_0000);
        tick();
`endif
        idle(2);

        // Randomized traffic from two well-behaved requesters.
        if_pend = 1'b0; dm_pend = 1'b0; dm_w = 1'b0;
        if_a = '0; dm_a = '0; dm_d = '0;
        for (int c = 0; c < 2000; c++) begin
            if (m_if_ack) if_pend = 1'b0;
            if (m_dm_ack) dm_pend = 1'b0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1; if_a = $urandom;
            end
            if (!dm_pend && $urandom_range(0, 3) == 0) begin
                dm_pend = 1'b1; dm_a = $urandom; dm_d = $urandom;
                dm_w = 1'($urandom_range(0, 1));
            end
            if (if_pend && m_port == 1 && $urandom_range(0, 9) == 0) if_pend = 1'b0;
            if (dm_pend && m_port == 2 && $urandom_range(0, 9) == 0) dm_pend = 1'b0;
            ir = if_pend;
            dr = dm_pend;
            drive(ir, if_a, dr, dm_w, dm_a, dm_d,
                  1'($urandom_range(0, 2) == 0), $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, the address width.
REQ-002 SHALL have parameter DW, default 32, the data width.
REQ-003 SHALL have parameter TMO_MAX, default 16, the timeout limit in cycles; it is used only with MEM_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port if_req  in  1  instruction-fetch request.
REQ-007 SHALL have port if_addr  in  AW  fetch address.
REQ-008 SHALL have ports if_rdata  out  DW (fetched word) and if_ack  out  1 (fetch-done pulse).
REQ-009 SHALL have port if_stall  out  1  hold-PC/IFID indication.
REQ-010 SHALL have ports dm_req  in  1, dm_we  in  1, dm_addr  in  AW and dm_wdata  in  DW for data-stage access.
REQ-011 SHALL have ports dm_rdata  out  DW, dm_ack  out  1 and dm_stall  out  1.
REQ-012 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  AW and mem_wdata  out  DW to the single-port memory.
REQ-013 SHALL have ports mem_rdata  in  DW and mem_ready  in  1  from the memory (completion strobe).
REQ-014 SHALL have port err  out  1  timeout-abort pulse.

Function
REQ-015 SHALL implement states IDLE, BUSY_IF and BUSY_DM.
REQ-016 In IDLE: dm_req=1 -> BUSY_DM; else if_req=1 -> BUSY_IF; else stay in IDLE (data has priority, being the older instruction).
REQ-017 On entry to a BUSY state, SHALL latch the served port's addr/we/wdata into registers; mem_* SHALL be driven only from these registers (if port: we=0, wdata=0).
REQ-018 mem_req SHALL be 1 in every BUSY cycle and 0 in IDLE; mem_addr, mem_we and mem_wdata SHALL be stable while mem_req=1.
REQ-019 Completion cycle = BUSY state with mem_ready=1: rdata register <= mem_rdata (loads and fetches only; stores leave dm_rdata unchanged).
REQ-020 The matching *_ack SHALL pulse exactly one cycle, on the cycle after completion; *_rdata SHALL be valid from that cycle until the next completion for the same port.
REQ-021 In the completion cycle, the next state SHALL be: the other port's BUSY state if that port is requesting, else IDLE; the just-served port SHALL NOT be re-granted in that cycle.
REQ-022 Back-to-back alternation SHALL add zero bubble cycles on mem_req.
REQ-023 SHALL define if_stall = if_req & ~if_ack and dm_stall = dm_req & ~dm_ack, both combinational.
REQ-024 A requester SHALL hold req/addr until ack; a req dropped mid-transaction SHALL NOT abort it, and the ack SHALL still pulse.
REQ-025 mem_ready outside BUSY SHALL be ignored.
REQ-026 if_req and dm_req rising in the same IDLE cycle -> dm is served first, and if is served with zero bubble after it.

Reset
REQ-027 rst=1 SHALL force IDLE; mem_req, mem_we, if_ack, dm_ack and err = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0.
REQ-028 A reset asserted mid-transaction SHALL abort the transaction with no ack, and it SHALL NOT complete after release.

Configuration
REQ-029 With MEM_ARB_TIMEOUT_EN defined: a cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-030 With MEM_ARB_TIMEOUT_EN defined: a count of TMO_MAX SHALL return the block to IDLE, pulse err for 1 cycle, pulse the served port's ack, and leave its rdata unchanged.
REQ-031 Without MEM_ARB_TIMEOUT_EN: err SHALL be tied to 0, no counter SHALL exist, and a BUSY state SHALL wait indefinitely.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY_IF, BUSY_DM) and the port-id constants PORT_IF and PORT_DM.
REQ-033 SHALL be a single module with no sub-module; the timeout counter SHALL be inline under the macro.

Verification
REQ-034 SHALL cover: if_req=1, if_addr=0x10, mem_ready 2 cycles after mem_req -> mem_addr=0x10, mem_we=0; if_ack one cycle later; if_rdata=mem_rdata; if_stall=1 for 3 cycles.
REQ-035 SHALL cover: if_req and dm_req (we=1, addr=0x40, wdata=0xDEADBEEF) in the same cycle -> dm served first with mem_we=1; if mem_req follows with no gap; dm_ack precedes if_ack.
REQ-036 SHALL cover: dm load at addr 0x8 held under continuous if_req -> grants alternate dm, if, dm, with each ack pulse exactly 1 cycle long.
REQ-037 SHALL cover: rst pulsed while in BUSY_DM -> mem_req=0 next cycle, no dm_ack, state IDLE, all outputs 0.
REQ-038 SHALL cover: with MEM_ARB_TIMEOUT_EN and TMO_MAX=4, mem_ready held 0 -> err and if_ack pulse after 4 BUSY cycles, then IDLE; without the macro -> mem_req stays 1 for 100 cycles and err=0.
